// File: rtl/hazard_ctrl_md.sv
// D-stage hazard control: Tuse/Tnew RAW stalls, HI/LO busy
// tracking with per-op latency, bubble insertion, stall counter.
module hazard_ctrl_md #(
  parameter int REG_AW      = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [T_W-1:0]    D_Tuse_rs,
  input  logic [T_W-1:0]    D_Tuse_rt,
  input  logic              D_is_md,
  input  logic [REG_AW-1:0] E_wa,
  input  logic [T_W-1:0]    E_Tnew,
  input  logic [REG_AW-1:0] M_wa,
  input  logic [T_W-1:0]    M_Tnew,
  input  logic              E_md_start,
  input  logic              E_md_div,
  output logic              en_PC,
  output logic              en_FD,
  output logic              flush_DE,
  output logic              md_busy,
  output logic [7:0]        md_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  logic [7:0]        md_cnt_q, md_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              e_rs, m_rs, e_rt, m_rt;
  logic              stall_rs, stall_rt, stall_md, stall;

  assign e_rs = (E_wa == D_rs) && (E_wa != '0)
              && (D_Tuse_rs < E_Tnew);
  assign m_rs = (M_wa == D_rs) && (M_wa != '0)
              && (D_Tuse_rs < M_Tnew);
  assign e_rt = (E_wa == D_rt) && (E_wa != '0)
              && (D_Tuse_rt < E_Tnew);
  assign m_rt = (M_wa == D_rt) && (M_wa != '0)
              && (D_Tuse_rt < M_Tnew);

  assign stall_rs = e_rs | m_rs;
  assign stall_rt = e_rt | m_rt;

  // Busy covers the start cycle itself, so no gap before the count loads.
  assign md_busy  = E_md_start | (md_cnt_q != 8'd0);
  assign stall_md = D_is_md & md_busy;
  assign stall    = stall_rs | stall_rt | stall_md;

  assign en_PC    = ~stall;
  assign en_FD    = ~stall;
  assign flush_DE = stall;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (E_md_start) begin
      md_cnt_d = E_md_div ? DIV_N : MULT_N;
    end else if (md_cnt_q != 8'd0) begin
      md_cnt_d = md_cnt_q - 8'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_cnt    = md_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule
